// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, condition codes,
// NZCV flag bit positions, FSM encoding and the opcode->latency helper.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_ORR = 4'b0100;
  localparam logic [3:0] OP_EOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_MVN = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  // Fields held for the duration of one instruction (register indices are
  // REG_AW-wide and live next to this in the top).
  typedef struct packed {
    logic [3:0]  op;
    logic        s;
    logic [15:0] iv;
  } instr_ctl_t;

  // Cycles spent in EXEC for a given opcode.
  function automatic int op_lat(input logic [3:0] op, input int mul_lat, input int alu_lat);
    return (op == OP_MUL) ? mul_lat : alu_lat;
  endfunction

  // Legal opcodes span OP_ADD through OP_CMP.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, register-file, ALU and writeback bus of the issue controller.
// master = controller side, slave = surrounding datapath / instruction source.
interface alu_issue_ctrl_if #(parameter int REG_AW = 4);
  logic              Instr_Valid;
  logic              Instr_Ready;
  logic [3:0]        OpCode;
  logic [3:0]        Cond;
  logic              S;
  logic [REG_AW-1:0] Rd;
  logic [REG_AW-1:0] Rn;
  logic [REG_AW-1:0] Rm;
  logic [15:0]       IV;

  logic [REG_AW-1:0] Rf_Addr1;
  logic [REG_AW-1:0] Rf_Addr2;
  logic [31:0]       Rf_Data1;
  logic [31:0]       Rf_Data2;

  logic [31:0]       Alu_Reg1;
  logic [31:0]       Alu_Reg2;
  logic [15:0]       Alu_IV;
  logic [3:0]        Alu_OpCode;
  logic              Alu_S;
  logic [3:0]        Alu_Flag;
  logic [31:0]       Alu_Result;
  logic [3:0]        Alu_New_Flag;

  logic              Wb_En;
  logic [REG_AW-1:0] Wb_Addr;
  logic [31:0]       Wb_Data;
  logic [3:0]        Flag;
  logic              Done;
  logic              Skipped;
  logic              Illegal;

  modport master (
    input  Instr_Valid, OpCode, Cond, S, Rd, Rn, Rm, IV,
    input  Rf_Data1, Rf_Data2, Alu_Result, Alu_New_Flag,
    output Instr_Ready, Rf_Addr1, Rf_Addr2,
    output Alu_Reg1, Alu_Reg2, Alu_IV, Alu_OpCode, Alu_S, Alu_Flag,
    output Wb_En, Wb_Addr, Wb_Data, Flag, Done, Skipped, Illegal
  );

  modport slave (
    output Instr_Valid, OpCode, Cond, S, Rd, Rn, Rm, IV,
    output Rf_Data1, Rf_Data2, Alu_Result, Alu_New_Flag,
    input  Instr_Ready, Rf_Addr1, Rf_Addr2,
    input  Alu_Reg1, Alu_Reg2, Alu_IV, Alu_OpCode, Alu_S, Alu_Flag,
    input  Wb_En, Wb_Addr, Wb_Data, Flag, Done, Skipped, Illegal
  );
endinterface

// File: rtl/alu_issue_ctrl_cond_check.sv
// Combinational evaluation of a 4-bit condition code against NZCV flags.
module cond_check
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flag,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flag[FLAG_N];
  assign z = flag[FLAG_Z];
  assign c = flag[FLAG_C];
  assign v = flag[FLAG_V];

  // Decode condition code into pass/fail.
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer for the ALU datapath: accepts one instruction,
// checks its condition, holds operands on the ALU for the opcode latency,
// then writes back and updates NZCV.
// Optional feature macro: ALU_PERF_CNT_EN adds retired/skipped counters.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 3,
  parameter int ALU_LAT = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  alu_issue_ctrl_if.master   bus
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]        Perf_Retired,
  output logic [31:0]        Perf_Skipped
`endif
);

  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e            state_q, state_d;
  instr_ctl_t        ctl_q;
  logic [REG_AW-1:0] rd_q, rn_q, rm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       res_q;
  logic [3:0]        nflag_q;
  logic [3:0]        flag_q;
  logic              cond_fail_q;

  logic              cond_pass;
  logic              accept;
  logic              go_exec;

  cond_check u_cond_check (
    .cond (bus.Cond),
    .flag (flag_q),
    .pass (cond_pass)
  );

  assign accept  = bus.Instr_Valid && (state_q == ST_IDLE);
  assign go_exec = cond_pass && op_legal(bus.OpCode);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = go_exec ? ST_EXEC : ST_SKIP;
      ST_EXEC: if (cnt_q == '0) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_SKIP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch, EXEC countdown, result capture and flag update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctl_q       <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      nflag_q     <= '0;
      flag_q      <= '0;
      cond_fail_q <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q       <= '{op: bus.OpCode, s: bus.S, iv: bus.IV};
        rd_q        <= bus.Rd;
        rn_q        <= bus.Rn;
        rm_q        <= bus.Rm;
        cnt_q       <= CNT_W'(op_lat(bus.OpCode, MUL_LAT, ALU_LAT) - 1);
        // Condition failure wins over an illegal opcode when both apply.
        cond_fail_q <= !cond_pass;
      end
      if (state_q == ST_EXEC) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else begin
          res_q   <= bus.Alu_Result;
          nflag_q <= bus.Alu_New_Flag;
        end
      end
      // CMP exists only to set flags, so it updates them regardless of S.
      if ((state_q == ST_WB) && (ctl_q.s || (ctl_q.op == OP_CMP))) begin
        flag_q <= nflag_q;
      end
    end
  end

  assign bus.Flag = flag_q;

  // State-decoded outputs; everything idles at zero outside its state.
  always_comb begin
    bus.Instr_Ready = 1'b0;
    bus.Rf_Addr1    = '0;
    bus.Rf_Addr2    = '0;
    bus.Alu_Reg1    = '0;
    bus.Alu_Reg2    = '0;
    bus.Alu_IV      = '0;
    bus.Alu_OpCode  = '0;
    bus.Alu_S       = 1'b0;
    bus.Alu_Flag    = '0;
    bus.Wb_En       = 1'b0;
    bus.Wb_Addr     = '0;
    bus.Wb_Data     = '0;
    bus.Done        = 1'b0;
    bus.Skipped     = 1'b0;
    bus.Illegal     = 1'b0;
    case (state_q)
      ST_IDLE: bus.Instr_Ready = 1'b1;
      ST_EXEC: begin
        bus.Rf_Addr1   = rn_q;
        bus.Rf_Addr2   = rm_q;
        bus.Alu_Reg1   = bus.Rf_Data1;
        bus.Alu_Reg2   = bus.Rf_Data2;
        bus.Alu_IV     = ctl_q.iv;
        bus.Alu_OpCode = ctl_q.op;
        bus.Alu_S      = ctl_q.s;
        bus.Alu_Flag   = flag_q;
      end
      ST_WB: begin
        bus.Done    = 1'b1;
        bus.Wb_En   = (ctl_q.op != OP_CMP);
        bus.Wb_Addr = rd_q;
        bus.Wb_Data = res_q;
      end
      ST_SKIP: begin
        bus.Done    = 1'b1;
        bus.Skipped = cond_fail_q;
        bus.Illegal = !cond_fail_q;
      end
      default: ;
    endcase
  end

`ifdef ALU_PERF_CNT_EN
  // Retired / skipped instruction counters, free-running with wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Perf_Retired <= '0;
      Perf_Skipped <= '0;
    end else begin
      if (state_q == ST_WB)   Perf_Retired <= Perf_Retired + 32'd1;
      if (state_q == ST_SKIP) Perf_Skipped <= Perf_Skipped + 32'd1;
    end
  end
`endif

endmodule
